clock_set_controller: RTL and testbench
=======================================

// Module: clock_set_controller
// PURPOSE
//  Sequencer for the hh:mm:ss timekeeping datapath. Generates the 1 Hz advance
//  enable from the system clock and runs a two-button time-set state machine.
//  While the user is editing, the controller freezes timekeeping. On confirm it
//  issues a one-cycle parallel load of hours and minutes; the datapath clears seconds on load.
//  Sits between the board buttons and the timekeeping counter block.
// PARAMETERS
//  TICK_DIV     50_000_000  clk cycles per tick_1hz pulse (>=2)
//  SYNC_STAGES  2           button synchronizer flops (>=2)
//  BLINK_DIV    12_500_000  clk cycles per blink toggle while editing (>=1)
// PORTS
//  clk           in   1  system clock, all logic on posedge
//  reset         in   1  asynchronous, active-high; returns block to RUN
//  btn_mode      in   1  raw, debounced, asynchronous mode/confirm button
//  btn_inc       in   1  raw, debounced, asynchronous increment button
//  cur_hours     in   6  live hours from datapath (0..23)
//  cur_minutes   in   6  live minutes from datapath (0..59)
//  tick_1hz      out  1  one-cycle advance pulse to datapath
//  run_en        out  1  1 = datapath may count
//  load          out  1  one-cycle parallel-load strobe (seconds <= 0 on load)
//  load_hours    out  6  hours value qualified by load
//  load_minutes  out  6  minutes value qualified by load
//  mode          out  2  0 RUN, 1 SET_HR, 2 SET_MIN, 3 COMMIT
//  blink         out  1  display-blink for field under edit; 0 in RUN
// BEHAVIOUR
//  Reset: state RUN; prescaler, blink counter and edit regs at 0; all outputs 0.
//  Input path: each button passes through SYNC_STAGES flops, then a rising-edge
//   detector. The pulse is used SYNC_STAGES+1 cycles after the input rises.
//   A held button yields exactly one edge.
//  FSM, edges only:
//   RUN     --mode--> SET_HR   captures edit_h <= cur_hours and edit_m <= cur_minutes.
//           Out-of-range values (hours >23, minutes >59) are captured as 0.
//   SET_HR  --inc-->  edit_h <= (edit_h==23) ? 0 : edit_h+1
//           --mode--> SET_MIN
//   SET_MIN --inc-->  edit_m <= (edit_m==59) ? 0 : edit_m+1
//           --mode--> COMMIT
//   COMMIT  unconditional -> RUN after exactly one cycle. During this cycle
//           load=1, load_hours=edit_h and load_minutes=edit_m.
//  inc in RUN or COMMIT: ignored. mode and inc edges in the same cycle: mode wins
//   and inc is dropped.
//  load_hours/minutes: driven from edit regs at all times, meaningful only with load.
//  run_en = (state==RUN), registered output; it is 0 in the COMMIT cycle.
//  Prescaler: counts 0..TICK_DIV-1 only in RUN. tick_1hz=1 for the cycle
//   where count==TICK_DIV-1, then the count wraps to 0. The count is held at 0
//   in SET_HR, SET_MIN and COMMIT, so the first tick after commit is a full
//   TICK_DIV cycles later. No tick is emitted outside RUN.
//  Blink: free counter, active in SET_* states; blink toggles each BLINK_DIV.
//   Counter and blink are forced to 0 in RUN and COMMIT.
//  Reset mid-edit: immediate return to RUN, edits discarded, no load pulse.
//  All arithmetic is 6-bit unsigned. Prescaler width is $clog2(TICK_DIV).
// STRUCTURE
//  clock_pkg: state typedef (RUN/SET_HR/SET_MIN/COMMIT, 2-bit),
//   MAX_HOURS=23, MAX_MINUTES=59, TIME_W=6; shared with the datapath.
//  Sub-module button_sync_edge (param SYNC_STAGES): synchronizer plus rising
//   edge pulse; instantiated once per button.
//  Top level holds the FSM, edit regs, prescaler and blink counter.
// TESTING (TICK_DIV=4, BLINK_DIV=2, SYNC_STAGES=2)
//  1 Free run from reset: tick_1hz pulses on cycles 4, 8, 12 after reset
//    release; run_en=1; load never asserts.
//  2 Set 09:30 -> 11:00: mode, inc x2, mode, then inc x30 so minutes go 30->59->0.
//    Then mode: one load with hours=11, minutes=0; mode returns to 0, next tick
//    arrives 4 cycles after the COMMIT cycle.
//  3 Wrap: capture hours=23, inc once in SET_HR -> edit_h=0; capture
//    cur_hours=40 -> edit_h=0.
//  4 Simultaneous: in SET_HR assert mode and inc edges in the same cycle ->
//    state SET_MIN, edit_h unchanged. Hold btn_inc high for 20 cycles -> +1 only.
//  5 Reset mid-edit: in SET_MIN with edit_m=17 assert reset -> all outputs 0,
//    mode=0, no load; after release, first tick arrives 4 cycles later.
//  6 No tick while editing: stay in SET_HR 40 cycles -> tick_1hz=0 and run_en=0
//    throughout; blink toggles every 2 cycles.

Source files
------------

// File: rtl/clock_pkg.sv
// Purpose: shared types and constants for the hh:mm:ss timekeeping datapath
//          and its set controller.
// Contents: TIME_W, MAX_HOURS, MAX_MINUTES, state_e, and small helpers
//           for wrap-around increment, range-checked capture and
//           edit-state decode.
package clock_pkg;

  localparam int unsigned TIME_W = 6;

  localparam logic [TIME_W-1:0] MAX_HOURS   = 6'd23;
  localparam logic [TIME_W-1:0] MAX_MINUTES = 6'd59;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_e;

  // Increment with wrap to zero after the field maximum.
  function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] lim);
    return (v == lim) ? '0 : v + TIME_W'(1);
  endfunction

  // Values outside the legal field range are captured as zero.
  function automatic logic [TIME_W-1:0] capture(input logic [TIME_W-1:0] v,
                                                input logic [TIME_W-1:0] lim);
    return (v > lim) ? '0 : v;
  endfunction

  function automatic logic is_edit(input state_e s);
    return (s == SET_HR) || (s == SET_MIN);
  endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Purpose: synchronize one asynchronous (already debounced) button and
//          produce a single-cycle pulse on its rising edge.
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous, active-high
//   btn_i    in  raw button level
//   rise_c_o out one-cycle pulse, combinational from registered state,
//                valid SYNC_STAGES+1 clock edges after btn_i rises
module button_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_c_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain plus one delay flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // A held button produces exactly one pulse.
  assign rise_c_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/clock_set_controller.sv
// Purpose: sequencer for the hh:mm:ss datapath. Generates the 1 Hz advance
//          enable and runs the two-button time-set state machine; freezes
//          timekeeping while editing and issues a one-cycle load on confirm.
// Ports:
//   clk, reset              system clock, async active-high reset
//   btn_mode, btn_inc       raw debounced buttons
//   cur_hours, cur_minutes  live time from the datapath
//   tick_1hz                one-cycle advance pulse (RUN only)
//   run_en                  1 while the datapath may count
//   load                    one-cycle parallel-load strobe
//   load_hours/minutes      edit registers, qualified by load
//   mode                    current state (RUN/SET_HR/SET_MIN/COMMIT)
//   blink                   blink for the field under edit, 0 otherwise
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BLINK_DIV   = 12_500_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic [TIME_W-1:0] cur_hours,
  input  logic [TIME_W-1:0] cur_minutes,
  output logic              tick_1hz,
  output logic              run_en,
  output logic              load,
  output logic [TIME_W-1:0] load_hours,
  output logic [TIME_W-1:0] load_minutes,
  output logic [1:0]        mode,
  output logic              blink
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

  logic mode_rise;
  logic inc_rise;

  state_e            state_q, state_d;
  logic [TIME_W-1:0] edit_h_q, edit_h_d;
  logic [TIME_W-1:0] edit_m_q, edit_m_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic              blink_q, blink_d;
  logic              tick_q, tick_d;
  logic              run_en_q, run_en_d;
  logic              load_q, load_d;

  button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mode (
    .clk      (clk),
    .reset    (reset),
    .btn_i    (btn_mode),
    .rise_c_o (mode_rise)
  );

  button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_inc (
    .clk      (clk),
    .reset    (reset),
    .btn_i    (btn_inc),
    .rise_c_o (inc_rise)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next-state logic: mode edges advance, COMMIT lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mode_rise) state_d = SET_HR;
      SET_HR:  if (mode_rise) state_d = SET_MIN;
      SET_MIN: if (mode_rise) state_d = COMMIT;
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    edit_h_d = edit_h_q;
    edit_m_d = edit_m_q;
    pre_d    = '0;
    tick_d   = 1'b0;
    blk_d    = '0;
    blink_d  = 1'b0;
    run_en_d = (state_d == RUN);
    load_d   = (state_d == COMMIT);

    // mode wins over a simultaneous inc edge
    case (state_q)
      RUN: begin
        if (mode_rise) begin
          edit_h_d = capture(cur_hours, MAX_HOURS);
          edit_m_d = capture(cur_minutes, MAX_MINUTES);
        end
      end
      SET_HR:  if (inc_rise && !mode_rise) edit_h_d = wrap_inc(edit_h_q, MAX_HOURS);
      SET_MIN: if (inc_rise && !mode_rise) edit_m_d = wrap_inc(edit_m_q, MAX_MINUTES);
      default: ;
    endcase

    // Prescaler restarts at 0 on every entry into RUN, so the first tick is a full period away.
    if ((state_q == RUN) && (state_d == RUN)) begin
      pre_d  = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);
      tick_d = (pre_d == PRE_MAX);
    end

    // Blink counter runs continuously across SET_HR and SET_MIN.
    if (is_edit(state_q) && is_edit(state_d)) begin
      if (blk_q == BLK_MAX) begin
        blk_d   = '0;
        blink_d = ~blink_q;
      end else begin
        blk_d   = blk_q + BLK_W'(1);
        blink_d = blink_q;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edit_h_q <= '0;
      edit_m_q <= '0;
      pre_q    <= '0;
      tick_q   <= 1'b0;
      blk_q    <= '0;
      blink_q  <= 1'b0;
      run_en_q <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      edit_h_q <= edit_h_d;
      edit_m_q <= edit_m_d;
      pre_q    <= pre_d;
      tick_q   <= tick_d;
      blk_q    <= blk_d;
      blink_q  <= blink_d;
      run_en_q <= run_en_d;
      load_q   <= load_d;
    end
  end

  assign tick_1hz     = tick_q;
  assign run_en       = run_en_q;
  assign load         = load_q;
  assign load_hours   = edit_h_q;
  assign load_minutes = edit_m_q;
  assign mode         = state_q;
  assign blink        = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller with TICK_DIV=4, BLINK_DIV=2, SYNC_STAGES=2.
// Expected load payloads are queued when the confirm press is driven and
// popped when the load strobe appears.
module tb_clock_set_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       tick_1hz;
  logic       run_en;
  logic       load;
  logic [5:0] load_hours;
  logic [5:0] load_minutes;
  logic [1:0] mode;
  logic       blink;

  int total = 0;
  int bad   = 0;
  int load_seen = 0;
  logic [11:0] exp_q[$];

  clock_set_controller #(
    .TICK_DIV    (4),
    .SYNC_STAGES (2),
    .BLINK_DIV   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .cur_hours    (cur_hours),
    .cur_minutes  (cur_minutes),
    .tick_1hz     (tick_1hz),
    .run_en       (run_en),
    .load         (load),
    .load_hours   (load_hours),
    .load_minutes (load_minutes),
    .mode         (mode),
    .blink        (blink)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load === 1'b1) load_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply reset for a few cycles; returns just after release at a negedge.
  task automatic apply_reset();
    reset = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Press buttons at a negedge, hold, release and let the state settle.
  task automatic press(input logic m, input logic i, input int hold);
    btn_mode = m;
    btn_inc  = i;
    repeat (hold) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Confirm from SET_MIN and check the load strobe against the scoreboard.
  // Returns at the negedge where load is observed.
  task automatic commit_expect(input logic [5:0] h, input logic [5:0] m);
    logic [11:0] exp;
    bit found;
    exp_q.push_back({h, m});
    found = 1'b0;
    btn_mode = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 1) btn_mode = 1'b0;
      if (load === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    btn_mode = 1'b0;
    exp = exp_q.pop_front();
    total++;
    if (!found) begin
      bad++;
      $display("FAIL commit_timeout: no load within 20 cycles, expected %0d:%0d", exp[11:6], exp[5:0]);
    end else begin
      if ({load_hours, load_minutes} !== exp) begin
        bad++;
        $display("FAIL load_value: got %0d:%0d expected %0d:%0d", load_hours, load_minutes, exp[11:6], exp[5:0]);
      end
      total++;
      if (mode !== 2'd3 || run_en !== 1'b0 || tick_1hz !== 1'b0) begin
        bad++;
        $display("FAIL commit_cycle: mode=%0d run_en=%0b tick=%0b expected mode=3 run_en=0 tick=0", mode, run_en, tick_1hz);
      end
    end
  endtask

  task automatic test_reset();
    cur_hours = 6'd0;
    cur_minutes = 6'd0;
    reset = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({tick_1hz, run_en, load, load_hours, load_minutes, mode, blink} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {tick_1hz, run_en, load, load_hours, load_minutes, mode, blink});
    end
  endtask

  task automatic test_free_run();
    int l0;
    apply_reset();
    l0 = load_seen;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      total++;
      if (tick_1hz !== ((k % 4) == 3)) begin
        bad++;
        $display("FAIL free_tick: cycle %0d tick=%0b expected %0b", k + 1, tick_1hz, (k % 4) == 3);
      end
      total++;
      if (run_en !== 1'b1 || mode !== 2'd0) begin
        bad++;
        $display("FAIL free_run_en: cycle %0d run_en=%0b mode=%0d expected 1,0", k + 1, run_en, mode);
      end
    end
    total++;
    if (load_seen !== l0) begin
      bad++;
      $display("FAIL free_no_load: loads=%0d expected %0d", load_seen, l0);
    end
  endtask

  task automatic test_set_time();
    apply_reset();
    cur_hours = 6'd9;
    cur_minutes = 6'd30;
    press(1'b1, 1'b0, 2);
    total++;
    if (mode !== 2'd1 || run_en !== 1'b0 || load_hours !== 6'd9 || load_minutes !== 6'd30) begin
      bad++;
      $display("FAIL set_capture: mode=%0d run_en=%0b edit=%0d:%0d expected 1,0,9:30", mode, run_en, load_hours, load_minutes);
    end
    press(1'b0, 1'b1, 2);
    press(1'b0, 1'b1, 2);
    total++;
    if (load_hours !== 6'd11) begin
      bad++;
      $display("FAIL set_inc_hours: got %0d expected 11", load_hours);
    end
    press(1'b1, 1'b0, 2);
    total++;
    if (mode !== 2'd2) begin
      bad++;
      $display("FAIL set_to_min: mode=%0d expected 2", mode);
    end
    for (int k = 0; k < 29; k++) press(1'b0, 1'b1, 2);
    total++;
    if (load_minutes !== 6'd59) begin
      bad++;
      $display("FAIL set_min_59: got %0d expected 59", load_minutes);
    end
    press(1'b0, 1'b1, 2);
    total++;
    if (load_minutes !== 6'd0) begin
      bad++;
      $display("FAIL set_min_wrap: got %0d expected 0", load_minutes);
    end
    commit_expect(6'd11, 6'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++;
      if (tick_1hz !== (k == 4)) begin
        bad++;
        $display("FAIL post_commit_tick: %0d cycles after commit tick=%0b expected %0b", k, tick_1hz, k == 4);
      end
      if (k == 1) begin
        total++;
        if (mode !== 2'd0 || run_en !== 1'b1 || load !== 1'b0) begin
          bad++;
          $display("FAIL post_commit_state: mode=%0d run_en=%0b load=%0b expected 0,1,0", mode, run_en, load);
        end
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    cur_hours = 6'd23;
    cur_minutes = 6'd10;
    press(1'b1, 1'b0, 2);
    total++;
    if (load_hours !== 6'd23) begin
      bad++;
      $display("FAIL wrap_capture23: got %0d expected 23", load_hours);
    end
    press(1'b0, 1'b1, 2);
    total++;
    if (load_hours !== 6'd0) begin
      bad++;
      $display("FAIL wrap_hours: got %0d expected 0", load_hours);
    end
    press(1'b1, 1'b0, 2);
    commit_expect(6'd0, 6'd10);
    repeat (4) @(negedge clk);
    cur_hours = 6'd40;
    cur_minutes = 6'd61;
    press(1'b0, 1'b1, 2);
    total++;
    if (mode !== 2'd0 || load_hours !== 6'd0) begin
      bad++;
      $display("FAIL inc_in_run: mode=%0d hours=%0d expected 0,0", mode, load_hours);
    end
    press(1'b1, 1'b0, 2);
    total++;
    if (mode !== 2'd1 || load_hours !== 6'd0 || load_minutes !== 6'd0) begin
      bad++;
      $display("FAIL capture_out_of_range: mode=%0d edit=%0d:%0d expected 1,0:0", mode, load_hours, load_minutes);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    cur_hours = 6'd5;
    cur_minutes = 6'd20;
    press(1'b1, 1'b0, 2);
    press(1'b1, 1'b1, 2);
    total++;
    if (mode !== 2'd2 || load_hours !== 6'd5) begin
      bad++;
      $display("FAIL simultaneous: mode=%0d hours=%0d expected 2,5", mode, load_hours);
    end
    press(1'b0, 1'b1, 20);
    total++;
    if (load_minutes !== 6'd21 || mode !== 2'd2) begin
      bad++;
      $display("FAIL held_inc: minutes=%0d mode=%0d expected 21,2", load_minutes, mode);
    end
  endtask

  task automatic test_reset_mid_edit();
    int l0;
    apply_reset();
    cur_hours = 6'd8;
    cur_minutes = 6'd15;
    press(1'b1, 1'b0, 2);
    press(1'b1, 1'b0, 2);
    press(1'b0, 1'b1, 2);
    press(1'b0, 1'b1, 2);
    total++;
    if (mode !== 2'd2 || load_minutes !== 6'd17) begin
      bad++;
      $display("FAIL mid_edit_setup: mode=%0d minutes=%0d expected 2,17", mode, load_minutes);
    end
    l0 = load_seen;
    reset = 1'b1;
    #1;
    total++;
    if ({tick_1hz, run_en, load, load_hours, load_minutes, mode, blink} !== 19'd0) begin
      bad++;
      $display("FAIL mid_edit_reset: got %b expected all zero",
               {tick_1hz, run_en, load, load_hours, load_minutes, mode, blink});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++;
      if (tick_1hz !== (k == 3)) begin
        bad++;
        $display("FAIL mid_edit_tick: cycle %0d tick=%0b expected %0b", k + 1, tick_1hz, k == 3);
      end
    end
    total++;
    if (load_seen !== l0 || mode !== 2'd0) begin
      bad++;
      $display("FAIL mid_edit_no_load: loads=%0d mode=%0d expected %0d,0", load_seen, mode, l0);
    end
  endtask

  task automatic test_no_tick_edit();
    logic b[40];
    int toggles;
    apply_reset();
    cur_hours = 6'd1;
    cur_minutes = 6'd2;
    repeat (3) @(negedge clk);
    total++;
    if (blink !== 1'b0) begin
      bad++;
      $display("FAIL blink_run: got %0b expected 0", blink);
    end
    press(1'b1, 1'b0, 2);
    toggles = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      b[k] = blink;
      total++;
      if (tick_1hz !== 1'b0 || run_en !== 1'b0 || mode !== 2'd1) begin
        bad++;
        $display("FAIL edit_frozen: cycle %0d tick=%0b run_en=%0b mode=%0d expected 0,0,1", k, tick_1hz, run_en, mode);
      end
      if (k >= 1 && b[k] !== b[k-1]) toggles++;
      if (k >= 2) begin
        total++;
        if (b[k] !== ~b[k-2]) begin
          bad++;
          $display("FAIL blink_period: cycle %0d blink=%0b expected %0b", k, b[k], ~b[k-2]);
        end
      end
    end
    total++;
    if (toggles < 18) begin
      bad++;
      $display("FAIL blink_toggles: got %0d expected at least 18", toggles);
    end
  endtask

  initial begin
    reset = 1'b1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    cur_hours = 6'd0;
    cur_minutes = 6'd0;
    @(negedge clk);
    test_reset();
    test_free_run();
    test_set_time();
    test_wrap();
    test_simultaneous();
    test_reset_mid_edit();
    test_no_tick_edit();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
